// File: rtl/booth_mul_seq_if.sv
// Handshake and result bus between a requester and the Booth multiplier.
// The requester drives the operands; the multiplier returns status and product halves.
interface booth_mul_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic             busy;
    logic             done;
    logic             x_en;
    logic [WIDTH-1:0] x_out;
    logic [WIDTH-1:0] a_out;

    modport master (
        output start,
        output mcand,
        output mplier,
        input  busy,
        input  done,
        input  x_en,
        input  x_out,
        input  a_out
    );

    modport slave (
        input  start,
        input  mcand,
        input  mplier,
        output busy,
        output done,
        output x_en,
        output x_out,
        output a_out
    );
endinterface

// File: rtl/booth_mul_seq.sv
// Sequential signed radix-2 Booth multiplier feeding the X register (low half)
// and the accumulator (high half); one Booth step per clock.
module booth_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst_b,
    booth_mul_seq_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH:0]   m_q;
    logic [WIDTH:0]   a_q;
    logic [WIDTH-1:0] q_q;
    logic             q1_q;
    logic [CW-1:0]    cnt;
    logic             busy_q;
    logic             done_q;
    logic             xen_q;
    logic [WIDTH-1:0] xo_q;
    logic [WIDTH-1:0] ao_q;

    logic [WIDTH:0]   t;
    logic [WIDTH:0]   sh_a;
    logic [WIDTH-1:0] sh_q;
    logic             sh_q1;
    logic             last;

    // One Booth step: add/subtract M, then arithmetic shift {T,Q,q_1} right by one.
    always_comb begin
        t = a_q;
        unique case ({q_q[0], q1_q})
            2'b01:   t = a_q + m_q;
            2'b10:   t = a_q - m_q;
            default: t = a_q;
        endcase
        sh_a  = {t[WIDTH], t[WIDTH:1]};
        sh_q  = {t[0], q_q[WIDTH-1:1]};
        sh_q1 = q_q[0];
        last  = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state  <= IDLE;
            m_q    <= '0;
            a_q    <= '0;
            q_q    <= '0;
            q1_q   <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            xen_q  <= 1'b0;
            xo_q   <= '0;
            ao_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        m_q    <= {bus.mcand[WIDTH-1], bus.mcand};
                        a_q    <= '0;
                        q_q    <= bus.mplier;
                        q1_q   <= 1'b0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_q  <= sh_a;
                    q_q  <= sh_q;
                    q1_q <= sh_q1;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        ao_q   <= sh_a[WIDTH-1:0];
                        xo_q   <= sh_q;
                        done_q <= 1'b1;
                        xen_q  <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    xen_q  <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.x_en  = xen_q;
    assign bus.x_out = xo_q;
    assign bus.a_out = ao_q;
endmodule

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
Sequential signed radix-2 Booth multiplier for the processor datapath. It sits directly upstream of the 16-bit X register. The low half of the product drives the X register data input, and a one-cycle load-enable pulse drives the X register enable. The high half is presented separately for the accumulator.

Parameters:
WIDTH, 16, operand width in bits; product is 2*WIDTH bits. Only the default is verified.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_b  input  1  reset; asynchronous, active-high (1 = reset), despite the name
start  input  1  request a multiply; sampled only in IDLE
mcand  input  WIDTH  multiplicand, two's complement; captured on the accepted start edge
mplier  input  WIDTH  multiplier, two's complement; captured on the accepted start edge
busy  output  1  1 from the accepted start edge until the DONE cycle ends
done  output  1  one-cycle pulse; the product is valid
x_en  output  1  load enable to the X register; identical timing to done
x_out  output  WIDTH  product bits [WIDTH-1:0]; feeds X register data input
a_out  output  WIDTH  product bits [2*WIDTH-1:WIDTH]

Behaviour:
- Reset (async, rst_b=1):
  - state=IDLE, busy=0, done=0, x_en=0.
  - x_out=0, a_out=0, all internal registers 0.
  - Reset mid-operation aborts immediately.
  - After release, the block waits in IDLE for a new start.
- Internal registers:
  - M: WIDTH+1 bits, sign-extended multiplicand.
  - A: WIDTH+1 bits, sign-extended accumulator.
  - Q: WIDTH bits.
  - q_1: 1 bit.
  - cnt: log2(WIDTH) bits.
- States: IDLE, RUN, DONE. No other states are reachable.
- IDLE, start=1 at edge k:
  - M={mcand[WIDTH-1],mcand}, A=0, Q=mplier, q_1=0, cnt=0.
  - busy=1, next state RUN.
- IDLE, start=0: hold all registers.
- RUN, one Booth step per edge:
  - Select T on {Q[0],q_1}: 00/11 -> T=A; 01 -> T=A+M; 10 -> T=A-M (WIDTH+1-bit arithmetic, no overflow possible).
  - Then {A,Q,q_1} <= arithmetic right shift by 1 of {T,Q,q_1}; the MSB of T is replicated.
  - cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge (16th step), next state is DONE.
  - That same edge loads a_out<=shifted A[WIDTH-1:0] and x_out<=shifted Q, and sets done=1, x_en=1.
- DONE (exactly one cycle):
  - done=1, x_en=1, busy=1.
  - Next edge: done=0, x_en=0, busy=0, state IDLE.
- Latency:
  - Start accepted at edge k; steps at edges k+1..k+16.
  - done/x_en high during the cycle after edge k+16, i.e. 17 cycles after acceptance.
  - The earliest next accepted start is edge k+18 (first IDLE cycle).
- x_out/a_out change only at the final RUN edge. They hold their value through IDLE until the next product completes.
- mcand/mplier changes after acceptance have no effect.
- start asserted while busy=1 (RUN or DONE) is ignored, not queued.
- start held high continuously: a new operation is accepted on the first IDLE edge after each DONE.
- Product is exact two's complement over 2*WIDTH bits for all operand pairs, including mcand=mplier=0x8000.

Test Plan:
1. Reset, then mcand=3, mplier=4, 1-cycle start -> 17 cycles later done=x_en=1 for one cycle, a_out=0x0000, x_out=0x000C; busy falls the following cycle.
2. mcand=0xFFFD (-3), mplier=7 -> a_out=0xFFFF, x_out=0xFFEB (-21); next, mcand=0x7FFF, mplier=0x8000 -> a_out=0xC000, x_out=0x8000.
3. mcand=0x8000, mplier=0x8000 -> a_out=0x4000, x_out=0x0000; mcand=0, mplier=0xFFFF -> a_out=0x0000, x_out=0x0000.
4. Start 2*3, then pulse start with 5*5 at cycles 5 and 17 (DONE) -> only 0x0000_0006 produced, exactly one done pulse; operand changes mid-run have no effect.
5. Assert rst_b at step 8 of a multiply -> busy, done, x_en, x_out, a_out read 0 immediately (before the next edge); no done pulse follows; a fresh 6*7 then yields x_out=0x002A with 17-cycle latency.
6. start held high for 60 cycles with mplier=0xFFFF, mcand=2 -> done pulses exactly every 18 cycles, each with a_out=0xFFFF, x_out=0xFFFE; x_en mirrors done every cycle.
